// File: rtl/alu_share_arb.sv
// alu_share_arb
// Shared-ALU arbiter and sequencer. Two requesters time-share one ALU
// datapath under round-robin arbitration. A granted command is latched,
// executed in the following cycle and its result is held for the winning
// port until that port takes it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid[1:0]/req_ready[1:0] command handshake, one bit per port
//   req_a0/req_b0/req_op0         port 0 operands and 3-bit opcode
//   req_a1/req_b1/req_op1         port 1 operands and 3-bit opcode
//   rsp_valid[1:0]/rsp_ready[1:0] response handshake, one bit per port
//   rsp_data/rsp_carry/rsp_zero   shared result, carry/borrow, zero flag
//   last_result                   most recently completed result
//   op_count                      completed-transaction counter (wraps)
module alu_share_arb #(
    parameter int   DATA_W    = 4,
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [2:0]        req_op0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [2:0]        req_op1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic [DATA_W-1:0] last_result,
    output logic [7:0]        op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              prio;
    logic              grant_id;
    logic              grant_sel;
    logic              handshake;
    logic              rsp_done;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [DATA_W:0]   alu_sum;

    // Grant selection: with both ports valid the priority pointer decides,
    // with only one valid that port wins. The ready is held low during reset
    // so nothing can be accepted on the reset edge.
    always_comb begin
        grant_sel = req_valid[1] & (~req_valid[0] | prio);
        req_ready = 2'b00;
        if (state == IDLE && !rst && (|req_valid)) begin
            req_ready = grant_sel ? 2'b10 : 2'b01;
        end
        handshake = |(req_valid & req_ready);
        rsp_done  = (state == RESP) && rsp_ready[grant_id];
    end

    // Next-state logic; the non-granted port's rsp_ready never matters.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU on the latched operands, so operand changes at the requester after
    // the handshake cannot disturb an in-flight command.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_sum   = {1'b0, a_q} + {1'b0, b_q};
        case (op_q)
            3'b000: begin
                alu_res   = alu_sum[DATA_W-1:0];
                alu_carry = alu_sum[DATA_W];
            end
            3'b001: begin
                alu_res   = a_q - b_q;
                alu_carry = (a_q < b_q);
            end
            3'b010:  alu_res = ~a_q;
            3'b011:  alu_res = a_q & b_q;
            3'b100:  alu_res = a_q | b_q;
            3'b101:  alu_res = a_q ^ b_q;
            3'b110:  alu_res = '0;
            default: alu_res[0] = (a_q == b_q);
        endcase
    end

    assign rsp_valid = (state == RESP) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    // State, command latch, result registers and completion bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prio        <= PRIO_INIT;
            grant_id    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_data    <= '0;
            rsp_carry   <= 1'b0;
            rsp_zero    <= 1'b0;
            last_result <= '0;
            op_count    <= 8'd0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                a_q      <= grant_sel ? req_a1 : req_a0;
                b_q      <= grant_sel ? req_b1 : req_b0;
                op_q     <= grant_sel ? req_op1 : req_op0;
                grant_id <= grant_sel;
                prio     <= ~grant_sel;
            end
            if (state == EXEC) begin
                rsp_data  <= alu_res;
                rsp_carry <= alu_carry;
                rsp_zero  <= (alu_res == '0);
            end
            if (rsp_done) begin
                last_result <= rsp_data;
                op_count    <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb
// Directed bench for alu_share_arb. Expected results are computed from a
// small reference model at each handshake, queued in a scoreboard and
// popped when the response appears.
module tb_alu_share_arb;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0] req_op0, req_op1;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_zero;
    logic [3:0] last_result;
    logic [7:0] op_count;

    typedef struct packed {
        logic [3:0] data;
        logic       carry;
        logic       zero;
    } exp_t;

    exp_t       sb[$];
    int         vectors;
    int         miscompares;
    logic [7:0] exp_count;
    logic [3:0] exp_last;

    alu_share_arb #(.DATA_W(4), .PRIO_INIT(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_op0    (req_op0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_op1    (req_op1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .last_result(last_result),
        .op_count   (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU model.
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        exp_t       e;
        logic [4:0] s;
        e = '0;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            3'd0: begin e.data = s[3:0]; e.carry = s[4]; end
            3'd1: begin e.data = a - b; e.carry = (a < b); end
            3'd2: e.data = ~a;
            3'd3: e.data = a & b;
            3'd4: e.data = a | b;
            3'd5: e.data = a ^ b;
            3'd6: e.data = 4'd0;
            default: e.data = (a == b) ? 4'd1 : 4'd0;
        endcase
        e.zero = (e.data == 4'd0);
        return e;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change only at the negative edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input int p, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        if (p == 0) begin
            req_a0 = a; req_b0 = b; req_op0 = op; req_valid[0] = 1'b1;
        end else begin
            req_a1 = a; req_b1 = b; req_op1 = op; req_valid[1] = 1'b1;
        end
    endtask

    task automatic release_port(input int p);
        req_valid[p] = 1'b0;
    endtask

    // Wait (bounded) for port p to be granted, queue its expected result and
    // step through the handshake edge. Returns in EXEC.
    task automatic wait_grant(input int p);
        int waits;
        waits = 0;
        #1;
        while (!req_ready[p] && waits < 20) begin
            tick();
            waits++;
        end
        check_output("grant", 32'(req_ready), (p == 0) ? 32'h1 : 32'h2);
        if (req_ready[p]) begin
            if (p == 0) sb.push_back(model(req_a0, req_b0, req_op0));
            else        sb.push_back(model(req_a1, req_b1, req_op1));
            tick();
        end
    endtask

    // Wait (bounded) for the response on port p, compare it to the
    // scoreboard, optionally stall it for 'hold' cycles, then complete it.
    task automatic collect(input int p, input int hold, input bit chk_lat);
        int         waits;
        exp_t       e;
        logic [1:0] want;
        want  = (p == 0) ? 2'b01 : 2'b10;
        waits = 0;
        while (rsp_valid == 2'b00 && waits < 20) begin
            check_output("ready_busy", 32'(req_ready), 32'h0);
            tick();
            waits++;
        end
        check_output("rsp_valid", 32'(rsp_valid), 32'(want));
        if (chk_lat) check_output("latency", 32'(waits), 32'd1);
        check_output("sb_nonempty", 32'(sb.size() > 0), 32'h1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check_output("rsp_data", 32'(rsp_data), 32'(e.data));
        check_output("rsp_carry", 32'(rsp_carry), 32'(e.carry));
        check_output("rsp_zero", 32'(rsp_zero), 32'(e.zero));
        for (int i = 0; i < hold; i++) begin
            rsp_ready[p]     = 1'b0;
            rsp_ready[1 - p] = 1'b1;
            tick();
            check_output("hold_valid", 32'(rsp_valid), 32'(want));
            check_output("hold_data", 32'(rsp_data), 32'(e.data));
            check_output("hold_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready[1 - p] = 1'b0;
        rsp_ready[p]     = 1'b1;
        tick();
        rsp_ready = 2'b00;
        exp_count = exp_count + 8'd1;
        exp_last  = e.data;
        check_output("op_count", 32'(op_count), 32'(exp_count));
        check_output("last_result", 32'(last_result), 32'(exp_last));
        check_output("rsp_done", 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_count   = 8'd0;
        exp_last    = 4'd0;
        rst         = 1'b1;
        req_valid   = 2'b11;
        rsp_ready   = 2'b00;
        req_a0 = 4'd0; req_b0 = 4'd0; req_op0 = 3'd0;
        req_a1 = 4'd0; req_b1 = 4'd0; req_op1 = 3'd0;

        // Reset values, with both ports requesting during reset.
        @(negedge clk);
        tick();
        check_output("rst_req_ready", 32'(req_ready), 32'h0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_output("rst_rsp_data", 32'(rsp_data), 32'h0);
        check_output("rst_rsp_carry", 32'(rsp_carry), 32'h0);
        check_output("rst_rsp_zero", 32'(rsp_zero), 32'h0);
        check_output("rst_last", 32'(last_result), 32'h0);
        check_output("rst_count", 32'(op_count), 32'h0);
        req_valid = 2'b00;
        rst       = 1'b0;

        // Port 0 add with rsp_ready held high from the start.
        $display("[TB] single add on port 0");
        rsp_ready[0] = 1'b1;
        apply_stimulus(0, 4'd3, 4'd4, 3'd0);
        wait_grant(0);
        release_port(0);
        collect(0, 0, 1'b1);

        // Port 1: add overflow, subtract with borrow, equality compare.
        $display("[TB] port 1 arithmetic");
        apply_stimulus(1, 4'd9, 4'd9, 3'd0);
        wait_grant(1);
        req_a1 = 4'd0;
        req_b1 = 4'd0;
        release_port(1);
        collect(1, 0, 1'b1);
        apply_stimulus(1, 4'd2, 4'd5, 3'd1);
        wait_grant(1);
        release_port(1);
        collect(1, 0, 1'b0);
        apply_stimulus(1, 4'd6, 4'd6, 3'd7);
        wait_grant(1);
        release_port(1);
        collect(1, 0, 1'b0);

        // Both ports continuously valid: grants alternate starting at port 0.
        $display("[TB] round-robin fairness");
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 4'(i), 4'd3, 3'd0);
            apply_stimulus(1, 4'(i + 5), 4'd2, 3'd1);
            wait_grant(i % 2);
            collect(i % 2, 0, 1'b0);
        end
        req_valid = 2'b00;

        // Stalled response on port 0 while port 1 waits.
        $display("[TB] response stall");
        apply_stimulus(0, 4'd12, 4'd5, 3'd5);
        wait_grant(0);
        release_port(0);
        apply_stimulus(1, 4'd4, 4'd4, 3'd7);
        collect(0, 5, 1'b0);
        check_output("grant_after_stall", 32'(req_ready), 32'h2);
        wait_grant(1);
        release_port(1);
        collect(1, 0, 1'b0);

        // Reset with a command in EXEC.
        $display("[TB] reset mid-operation");
        apply_stimulus(0, 4'd5, 4'd5, 3'd0);
        apply_stimulus(1, 4'd3, 4'd1, 3'd1);
        wait_grant(0);
        release_port(0);
        rst = 1'b1;
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        tick();
        check_output("mid_req_ready", 32'(req_ready), 32'h0);
        check_output("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check_output("mid_rsp_data", 32'(rsp_data), 32'h0);
        check_output("mid_rsp_carry", 32'(rsp_carry), 32'h0);
        check_output("mid_rsp_zero", 32'(rsp_zero), 32'h0);
        check_output("mid_count", 32'(op_count), 32'h0);
        check_output("mid_last", 32'(last_result), 32'h0);
        rst       = 1'b0;
        exp_count = 8'd0;
        exp_last  = 4'd0;
        #1;
        check_output("post_rst_valid", 32'(rsp_valid), 32'h0);
        check_output("post_rst_ready", 32'(req_ready), 32'h2);
        wait_grant(1);
        release_port(1);
        collect(1, 0, 1'b0);

        // Fill up to 251 completions since reset with random commands.
        $display("[TB] counter fill");
        for (int i = 0; i < 250; i++) begin
            apply_stimulus(i % 2, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           3'($urandom_range(0, 7)));
            wait_grant(i % 2);
            release_port(i % 2);
            collect(i % 2, 0, 1'b0);
        end

        // Logic ops; the last one is completion 256 and wraps the counter.
        $display("[TB] logic ops and counter wrap");
        for (int op = 2; op <= 6; op++) begin
            apply_stimulus(0, 4'hA, 4'h6, 3'(op));
            wait_grant(0);
            release_port(0);
            collect(0, 0, 1'b0);
        end
        check_output("count_wrap", 32'(op_count), 32'h0);
        check_output("final_last", 32'(last_result), 32'h0);
        check_output("final_zero", 32'(rsp_zero), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
